// File: rtl/memshare_regfile_loader.sv
// -----------------------------------------------------------------------------
// memshare_regfile_loader
//
// Write-side programmer for the L1PA type-0 register file. It takes L1PA shift
// patterns from the host over a valid/ready stream, computes each pattern's
// shift delta, and packs {shift, delta, isGtr} into one type-0 page word. It
// then writes that word through the regFile write port of
// memShare_control_wrapper.
//
// Optional feature: `MEMSHARE_LOADER_LOCK_EN adds pipeCycle_busy_i. While that
// input is high, the stream is stalled so that no write can overlap an RFMU
// read of a sequence in flight.
//
// Ports
//   sys_clk, rstn        clock, asynchronous active-low reset
//   start_i              opens a sequence (honoured only in IDLE)
//   base_addr_i          first page of the sequence, sampled with start_i
//   pat_valid_i/ready_o  pattern beat handshake
//   pat_shift_i          L1PA shift value of the beat
//   pat_last_i           beat is the final pattern of the sequence
//   regType0_waddr_o     regFile write address
//   regType0_wdata_o     page word {shift, delta, isGtr}
//   regType0_we_o        regFile write enable
//   done_o               one-cycle pulse on the final write of a sequence
//   err_o                sticky error, cleared by the next accepted start_i
//   seq_len_o            pages written in the current or last sequence
//   pipeCycle_busy_i     (lock build only) RFMU busy, stalls the stream
// -----------------------------------------------------------------------------
module memshare_regfile_loader #(
    parameter int unsigned SHIFT_BITWIDTH      = 3,
    parameter int unsigned DELTA_BITWIDTH      = 3,
    parameter int unsigned SEQ_SIZE            = 8,
    parameter int unsigned TYPE0_ADDR_BITWIDTH = 6,
    parameter int unsigned TYPE0_REG_BITWIDTH  = 7,
    parameter int unsigned TYPE0_PAGE_NUM      = 64
) (
    input  logic                             sys_clk,
    input  logic                             rstn,
    input  logic                             start_i,
    input  logic [TYPE0_ADDR_BITWIDTH-1:0]   base_addr_i,
    input  logic                             pat_valid_i,
    output logic                             pat_ready_o,
    input  logic [SHIFT_BITWIDTH-1:0]        pat_shift_i,
    input  logic                             pat_last_i,
`ifdef MEMSHARE_LOADER_LOCK_EN
    input  logic                             pipeCycle_busy_i,
`endif
    output logic [TYPE0_ADDR_BITWIDTH-1:0]   regType0_waddr_o,
    output logic [TYPE0_REG_BITWIDTH-1:0]    regType0_wdata_o,
    output logic                             regType0_we_o,
    output logic                             done_o,
    output logic                             err_o,
    output logic [$clog2(SEQ_SIZE+1)-1:0]    seq_len_o
);

    // The page pointer has one extra bit so that "one past the last page" is
    // representable and can be flagged instead of wrapping to page 0.
    localparam int unsigned PTR_W = TYPE0_ADDR_BITWIDTH + 1;
    localparam int unsigned CNT_W = $clog2(SEQ_SIZE + 1);

    // Layout of one type-0 page word; is_gtr marks the last pattern.
    typedef struct packed {
        logic [SHIFT_BITWIDTH-1:0] shift;
        logic [DELTA_BITWIDTH-1:0] delta;
        logic                      is_gtr;
    } page_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                          state;
    state_t                          state_nxt;

    logic [PTR_W-1:0]                ptr;
    logic [PTR_W-1:0]                ptr_nxt;
    logic [SHIFT_BITWIDTH-1:0]       prev_shift;
    logic [SHIFT_BITWIDTH-1:0]       prev_shift_nxt;
    logic [CNT_W-1:0]                count;
    logic [CNT_W-1:0]                count_nxt;

    logic                            ready_q;
    logic                            ready_nxt;
    logic                            we_q;
    logic                            we_nxt;
    logic [TYPE0_ADDR_BITWIDTH-1:0]  waddr_q;
    logic [TYPE0_ADDR_BITWIDTH-1:0]  waddr_nxt;
    logic [TYPE0_REG_BITWIDTH-1:0]   wdata_q;
    logic [TYPE0_REG_BITWIDTH-1:0]   wdata_nxt;
    logic                            done_q;
    logic                            done_nxt;
    logic                            err_q;
    logic                            err_nxt;

    logic                            lock;
    logic                            accept;
    logic                            violation;
    logic                            good_beat;
    page_t                           page;

    // RFMU lock input; tied low when the feature is not built in.
`ifdef MEMSHARE_LOADER_LOCK_EN
    assign lock = pipeCycle_busy_i;
`else
    assign lock = 1'b0;
`endif

    // The registered ready already reflects last cycle's lock. Gating it with
    // the live lock also drops ready in the very first busy cycle.
    assign pat_ready_o = ready_q & ~lock;

    // Beat qualification. A violating beat is consumed but never written.
    assign accept    = (state == S_STREAM) && pat_valid_i && pat_ready_o;
    assign violation = accept && ((ptr >= PTR_W'(TYPE0_PAGE_NUM)) ||
                                  (count == CNT_W'(SEQ_SIZE)));
    assign good_beat = accept && !violation;

    // Page word of the current beat; delta wraps modulo 2^SHIFT_BITWIDTH.
    always_comb begin
        page.shift  = pat_shift_i;
        page.delta  = DELTA_BITWIDTH'(pat_shift_i - prev_shift);
        page.is_gtr = pat_last_i;
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (violation) begin
                    state_nxt = S_ERR;
                end else if (good_beat && pat_last_i) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; everything lands in registers below.
    always_comb begin
        ptr_nxt        = ptr;
        prev_shift_nxt = prev_shift;
        count_nxt      = count;
        ready_nxt      = (state_nxt == S_STREAM) && !lock;
        we_nxt         = 1'b0;
        waddr_nxt      = waddr_q;
        wdata_nxt      = wdata_q;
        done_nxt       = 1'b0;
        err_nxt        = err_q;

        // Open a new sequence.
        if ((state == S_IDLE) && start_i) begin
            ptr_nxt        = PTR_W'(base_addr_i);
            prev_shift_nxt = '0;
            count_nxt      = '0;
            err_nxt        = 1'b0;
        end

        // One page write per good beat, issued on the following cycle.
        if (good_beat) begin
            we_nxt         = 1'b1;
            waddr_nxt      = ptr[TYPE0_ADDR_BITWIDTH-1:0];
            wdata_nxt      = TYPE0_REG_BITWIDTH'(page);
            prev_shift_nxt = pat_shift_i;
            ptr_nxt        = ptr + PTR_W'(1);
            count_nxt      = count + CNT_W'(1);
            done_nxt       = pat_last_i;
        end

        if (violation) begin
            err_nxt = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            prev_shift <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr        <= ptr_nxt;
            prev_shift <= prev_shift_nxt;
            count      <= count_nxt;
            ready_q    <= ready_nxt;
            we_q       <= we_nxt;
            waddr_q    <= waddr_nxt;
            wdata_q    <= wdata_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
        end
    end

    assign regType0_we_o    = we_q;
    assign regType0_waddr_o = waddr_q;
    assign regType0_wdata_o = wdata_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign seq_len_o        = count;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// -----------------------------------------------------------------------------
// tb_memshare_regfile_loader
//
// Directed and randomized sequences for memshare_regfile_loader. Expected page
// writes come from a list-level model: page = base + i, and delta is the
// modular difference between consecutive shifts. The pages stop at the first
// page or length overflow.
// -----------------------------------------------------------------------------
module tb_memshare_regfile_loader;

    localparam int SEQ   = 8;
    localparam int PAGES = 64;

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic       start_i;
    logic [5:0] base_addr_i;
    logic       pat_valid_i;
    logic       pat_ready_o;
    logic [2:0] pat_shift_i;
    logic       pat_last_i;
    logic [5:0] regType0_waddr_o;
    logic [6:0] regType0_wdata_o;
    logic       regType0_we_o;
    logic       done_o;
    logic       err_o;
    logic [3:0] seq_len_o;
`ifdef MEMSHARE_LOADER_LOCK_EN
    logic       pipeCycle_busy_i;
`endif

    memshare_regfile_loader dut (
        .sys_clk          (sys_clk),
        .rstn             (rstn),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .pat_valid_i      (pat_valid_i),
        .pat_ready_o      (pat_ready_o),
        .pat_shift_i      (pat_shift_i),
        .pat_last_i       (pat_last_i),
`ifdef MEMSHARE_LOADER_LOCK_EN
        .pipeCycle_busy_i (pipeCycle_busy_i),
`endif
        .regType0_waddr_o (regType0_waddr_o),
        .regType0_wdata_o (regType0_wdata_o),
        .regType0_we_o    (regType0_we_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .seq_len_o        (seq_len_o)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Free-running tallies of writes and done pulses; sequences use deltas.
    int wr_tally   = 0;
    int done_tally = 0;
    always @(negedge sys_clk) begin
        if (regType0_we_o) wr_tally   <= wr_tally + 1;
        if (done_o)        done_tally <= done_tally + 1;
    end

    // Sequence description and model results.
    int          seq_base;
    int          seq_n;
    bit          seq_last;
    int          seq_sh [0:15];
    int unsigned exp_addr[$];
    int unsigned exp_data[$];
    int          exp_err;
    int          exp_done;
    int          drive_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: list of pages the sequence should produce.
    task automatic model();
        int prev;
        int page;
        int lst;
        int delta;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 0;
        prev    = 0;
        drive_n = seq_n;
        for (int i = 0; i < seq_n; i++) begin
            page = seq_base + i;
            if (i >= SEQ || page >= PAGES) begin
                exp_err = 1;
                drive_n = i + 1;
                break;
            end
            lst   = (seq_last && i == seq_n - 1) ? 1 : 0;
            delta = (seq_sh[i] - prev + 8) % 8;
            exp_addr.push_back(page);
            exp_data.push_back(seq_sh[i] * 16 + delta * 2 + lst);
            prev = seq_sh[i];
        end
        exp_done = (!exp_err && seq_last) ? 1 : 0;
    endtask

    // Offer one beat, wait for acceptance, return at the negedge after it.
    task automatic send_beat(input int sh, input bit lst, input bit gaps);
        int w;
        if (gaps && $urandom_range(0, 3) == 0) @(negedge sys_clk);
        pat_valid_i = 1'b1;
        pat_shift_i = 3'(sh);
        pat_last_i  = lst;
        w = 0;
        while (!pat_ready_o && w < 64) begin
            @(negedge sys_clk);
            w++;
        end
        if (w >= 64) check("ready_timeout", 32'(pat_ready_o), 32'd1);
        else @(negedge sys_clk);
        pat_valid_i = 1'b0;
        pat_last_i  = 1'b0;
    endtask

    task automatic start_seq(input int base);
        @(negedge sys_clk);
        start_i     = 1'b1;
        base_addr_i = 6'(base);
        @(negedge sys_clk);
        start_i = 1'b0;
    endtask

    // Full sequence: drive, check each write as it happens, then totals.
    task automatic run_seq(input string name);
        int wr0;
        int dn0;
        model();
        start_seq(seq_base);
        wr0 = wr_tally;
        dn0 = done_tally;
        check({name, ":ready_after_start"}, 32'(pat_ready_o), 32'd1);
        check({name, ":err_cleared"}, 32'(err_o), 32'd0);
        for (int i = 0; i < drive_n; i++) begin
            send_beat(seq_sh[i], seq_last && (i == seq_n - 1), 1'b1);
            if (i < exp_addr.size()) begin
                check({name, ":we"}, 32'(regType0_we_o), 32'd1);
                check({name, ":waddr"}, 32'(regType0_waddr_o), exp_addr[i]);
                check({name, ":wdata"}, 32'(regType0_wdata_o), exp_data[i]);
                if (seq_last && i == seq_n - 1) begin
                    check({name, ":done_on_last"}, 32'(done_o), 32'd1);
                    check({name, ":ready_drop"}, 32'(pat_ready_o), 32'd0);
                end
            end else begin
                check({name, ":no_write_on_violation"}, 32'(regType0_we_o), 32'd0);
                check({name, ":err_set"}, 32'(err_o), 32'd1);
                check({name, ":ready_drop_err"}, 32'(pat_ready_o), 32'd0);
            end
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        check({name, ":write_count"}, 32'(wr_tally - wr0), 32'(exp_addr.size()));
        check({name, ":done_count"}, 32'(done_tally - dn0), 32'(exp_done));
        check({name, ":err_final"}, 32'(err_o), 32'(exp_err));
        check({name, ":seq_len"}, 32'(seq_len_o), 32'(exp_addr.size()));
        check({name, ":idle_ready"}, 32'(pat_ready_o), 32'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        pat_valid_i = 1'b0;
        pat_shift_i = '0;
        pat_last_i  = 1'b0;
`ifdef MEMSHARE_LOADER_LOCK_EN
        pipeCycle_busy_i = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);

        // Reset values.
        check("rst:ready", 32'(pat_ready_o), 32'd0);
        check("rst:we", 32'(regType0_we_o), 32'd0);
        check("rst:waddr", 32'(regType0_waddr_o), 32'd0);
        check("rst:wdata", 32'(regType0_wdata_o), 32'd0);
        check("rst:done", 32'(done_o), 32'd0);
        check("rst:err", 32'(err_o), 32'd0);
        check("rst:seq_len", 32'(seq_len_o), 32'd0);
        rstn = 1'b1;
        @(negedge sys_clk);

        // Base 5, shifts 2,7,1.
        seq_base = 5; seq_n = 3; seq_last = 1'b1;
        seq_sh[0] = 2; seq_sh[1] = 7; seq_sh[2] = 1;
        run_seq("basic");

        // Single beat at the top page.
        seq_base = 63; seq_n = 1; seq_last = 1'b1; seq_sh[0] = 4;
        run_seq("single63");

        // Runs off the end of the page space.
        seq_base = 62; seq_n = 3; seq_last = 1'b0;
        seq_sh[0] = 1; seq_sh[1] = 5; seq_sh[2] = 6;
        run_seq("overflow");

        // Length overflow: SEQ+1 beats, no last.
        seq_base = 0; seq_n = SEQ + 1; seq_last = 1'b0;
        for (int i = 0; i < SEQ + 1; i++) seq_sh[i] = (i * 3) % 8;
        run_seq("too_long");

        // Start while not idle is ignored: a second start mid-stream must not
        // move the page pointer.
        start_seq(40);
        send_beat(2, 1'b0, 1'b0);
        start_i = 1'b1; base_addr_i = 6'd9;
        @(negedge sys_clk);
        start_i = 1'b0;
        send_beat(3, 1'b1, 1'b0);
        check("ign_start:waddr", 32'(regType0_waddr_o), 32'd41);
        check("ign_start:wdata", 32'(regType0_wdata_o), 32'((3 << 4) | (1 << 1) | 1));
        @(negedge sys_clk);

        // Reset after the second beat of a four-beat sequence.
        start_seq(10);
        send_beat(3, 1'b0, 1'b0);
        send_beat(5, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("midrst:we", 32'(regType0_we_o), 32'd0);
        check("midrst:ready", 32'(pat_ready_o), 32'd0);
        check("midrst:seq_len", 32'(seq_len_o), 32'd0);
        check("midrst:waddr", 32'(regType0_waddr_o), 32'd0);
        @(negedge sys_clk);
        rstn = 1'b1;
        seq_base = 20; seq_n = 2; seq_last = 1'b1;
        seq_sh[0] = 6; seq_sh[1] = 0;
        run_seq("after_rst");

        // Random sequences.
        for (int r = 0; r < 8; r++) begin
            seq_base = $urandom_range(0, PAGES - 1);
            seq_last = 1'($urandom_range(0, 1));
            if (seq_last) begin
                seq_n = $urandom_range(1, SEQ + 1);
            end else begin
                seq_n = SEQ + 1;
                if (PAGES - seq_base + 1 < seq_n) seq_n = PAGES - seq_base + 1;
            end
            for (int i = 0; i < 16; i++) seq_sh[i] = $urandom_range(0, 7);
            run_seq("random");
        end

`ifdef MEMSHARE_LOADER_LOCK_EN
        // Busy for four cycles while a beat is offered.
        @(negedge sys_clk);
        start_i = 1'b1; base_addr_i = 6'd30; pipeCycle_busy_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        pat_valid_i = 1'b1; pat_shift_i = 3'd6; pat_last_i = 1'b0;
        check("lock:ready_low", 32'(pat_ready_o), 32'd0);
        check("lock:we_low1", 32'(regType0_we_o), 32'd0);
        for (int j = 2; j <= 5; j++) begin
            @(negedge sys_clk);
            if (j == 4) pipeCycle_busy_i = 1'b0;
            check("lock:we_low", 32'(regType0_we_o), 32'd0);
        end
        @(negedge sys_clk);
        check("lock:first_write", 32'(regType0_we_o), 32'd1);
        check("lock:waddr", 32'(regType0_waddr_o), 32'd30);
        check("lock:wdata", 32'(regType0_wdata_o), 32'((6 << 4) | (6 << 1)));
        send_beat(3, 1'b1, 1'b0);
        check("lock:done", 32'(done_o), 32'd1);
        @(negedge sys_clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memshare_regfile_loader.md
# memShare_regFile_loader

Write-side programmer for the L1PA type-0 register file. Accepts L1PA shift-pattern sequences from the host over a valid/ready stream, computes each pattern's shift delta, packs {shift, delta, isGtr} into one type-0 page word and drives the regFile write port (regType0_waddr/wdata/we) of memShare_control_wrapper. The regFile read side consumes these pages through the RFMU.

## Interface
Parameters:
- SHIFT_BITWIDTH, `L1PA_SHIFT_BITWIDTH (3): width of one L1PA shift value
- DELTA_BITWIDTH, `L1PA_SHIFT_DELTA_WIDTH (3): width of shift delta; must equal SHIFT_BITWIDTH
- SEQ_SIZE, `L1PA_SEQ_SIZE (8): maximum patterns per sequence
- TYPE0_ADDR_BITWIDTH, `L1PA_REGFILE_ADDR_WIDTH (6): page address width
- TYPE0_REG_BITWIDTH, `L1PA_REGFILE_PAGE_WIDTH (7): page width; must equal SHIFT_BITWIDTH+DELTA_BITWIDTH+1
- TYPE0_PAGE_NUM, `L1PA_REGFILE_PAGE_NUM (64): number of pages

Ports:
- sys_clk  in  1  clock
- rstn  in  1  reset. Asynchronous, active-low.
- start_i  in  1  single-cycle pulse that opens a sequence. Accepted only in IDLE.
- base_addr_i  in  TYPE0_ADDR_BITWIDTH  first page of the sequence. Sampled on start_i.
- pat_valid_i  in  1  pattern beat valid
- pat_ready_o  out  1  loader can accept a beat
- pat_shift_i  in  SHIFT_BITWIDTH  L1PA shift value of the beat
- pat_last_i  in  1  beat is the final pattern of the sequence
- regType0_waddr_o  out  TYPE0_ADDR_BITWIDTH  regFile write address
- regType0_wdata_o  out  TYPE0_REG_BITWIDTH  page word {shift, delta, isGtr}
- regType0_we_o  out  1  regFile write enable
- done_o  out  1  one-cycle pulse when a sequence is fully written
- err_o  out  1  sticky error flag. Cleared by the next accepted start_i.
- seq_len_o  out  $clog2(SEQ_SIZE+1)  number of pages written in the current or last sequence

## Operation
- FSM states:
  - IDLE: start_i → STREAM. Loads page pointer ← base_addr_i, prev_shift ← 0, count ← 0, err_o ← 0.
  - STREAM: a beat is accepted when pat_valid_i && pat_ready_o.
    - pat_last_i on an accepted beat → FLUSH.
    - A rule violation → ERR.
  - FLUSH: one cycle. The last write is issued, then done_o pulses → IDLE.
  - ERR: err_o=1, pat_ready_o=0. Returns to IDLE on the next cycle, so err_o remains set while in IDLE.
- pat_ready_o = 1 only in STREAM (see Configuration).
- Per accepted beat:
  - delta = (pat_shift_i − prev_shift) mod 2^SHIFT_BITWIDTH.
  - wdata = {pat_shift_i, delta, pat_last_i}. The LSB is isGtr; isGtr = 1 marks the last pattern of the sequence.
  - prev_shift ← pat_shift_i, pointer ← pointer+1, count ← count+1.
- Violations. The offending beat is accepted but NOT written. Pages already written stay written. No done_o is issued.
  - An accepted beat whose page pointer is ≥ TYPE0_PAGE_NUM. There is no wrap-around.
  - An accepted beat with count == SEQ_SIZE, i.e. a (SEQ_SIZE+1)-th pattern.
- start_i outside IDLE is ignored.
- seq_len_o = count.

## Timing
- Reset values:
  - pat_ready_o=0, regType0_we_o=0, regType0_waddr_o=0, regType0_wdata_o=0
  - done_o=0, err_o=0, seq_len_o=0
  - FSM=IDLE
- start_i at cycle t → pat_ready_o=1 at t+1.
- Accepted beat at cycle t → regType0_we_o=1 with matching waddr/wdata at t+1. Outputs are registered, one write per beat.
- Back-to-back beats give back-to-back writes, sustaining 1 page/cycle.
- Last beat accepted at t → final write at t+1 (FLUSH), done_o at t+1, pat_ready_o=0 from t+1, IDLE at t+2.
- Violation beat at t → no write at t+1, err_o=1 from t+1.
- rstn asserted mid-sequence: all outputs return to reset values immediately and no further writes are issued. The partial sequence is left in the regFile.
- A single-pattern sequence (first beat carries pat_last_i) writes one page with delta = shift and isGtr=1.

## Configuration
- MEMSHARE_LOADER_LOCK_EN defined:
  - Adds input pipeCycle_busy_i (1 bit), driven by the memShare monitor.
  - While it is high, pat_ready_o is forced to 0, so no write can collide with an RFMU read of a sequence in flight.
  - A beat offered while locked waits and is accepted the cycle after pipeCycle_busy_i falls.
- MEMSHARE_LOADER_LOCK_EN undefined: the port is absent and pat_ready_o depends only on the FSM.

## Test plan
- Start at base 5 with shifts 2,7,1 (last on 1) → writes to pages 5,6,7 with wdata {2,2,0}, {7,5,0}, {1,2,1}; done_o at the final write cycle; seq_len_o=3.
- Single beat shift 4, last, at base 63 → one write to page 63, wdata {4,4,1}, done_o=1, err_o=0.
- Start at base 62 with three beats and no last → pages 62 and 63 written, third beat not written, err_o=1, no done_o; next start_i clears err_o.
- SEQ_SIZE+1 beats with no last → exactly SEQ_SIZE writes, err_o=1, seq_len_o=SEQ_SIZE.
- rstn pulsed after the second beat of a 4-beat sequence → we_o=0 immediately, FSM IDLE, pat_ready_o=0; a fresh start works normally.
- With MEMSHARE_LOADER_LOCK_EN: pipeCycle_busy_i=1 for 4 cycles while pat_valid_i=1 → no writes during the lock; first write 2 cycles after busy falls.
